// File: rtl/zion_basic_circuit_lib_pkg.sv
// zion_basic_circuit_lib_pkg
//   Types and constants shared by the basic circuit library.
//   skid_state_e : occupancy state of the two-entry skid register
//   OCNT_W       : width of the skid register occupancy count
package zion_basic_circuit_lib_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // no entries
        BUSY  = 2'd1,  // mainQ valid
        FULL  = 2'd2   // mainQ and skidQ valid
    } skid_state_e;

    localparam int OCNT_W = 2;

endpackage

// File: rtl/zion_basic_circuit_lib_skid_reg.sv
// zion_basic_circuit_lib_skid_reg
//   Two-entry valid/ready register slice (skid buffer). It registers the
//   forward data/valid path and the backward ready path. It sustains one
//   transfer per cycle and keeps strict FIFO order.
// Parameters:
//   WIDTH    data width (>= 1)
//   INI_DATA value loaded into both data registers on rst/clr
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   clr          synchronous active-high flush (rst has priority)
//   iVld/iRdy    upstream handshake, iDat upstream data
//   oVld/oRdy    downstream handshake, oDat downstream data (from mainQ)
//   oCnt         occupancy 0/1/2
module zion_basic_circuit_lib_skid_reg
    import zion_basic_circuit_lib_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              iVld,
    output logic              iRdy,
    input  logic [WIDTH-1:0]  iDat,
    output logic              oVld,
    input  logic              oRdy,
    output logic [WIDTH-1:0]  oDat,
    output logic [OCNT_W-1:0] oCnt
);

    if (WIDTH < 1) begin : g_width_chk
        $error("zion_basic_circuit_lib_skid_reg: WIDTH must be >= 1");
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_basic_circuit_lib_skid_reg: aborting on parameter error");
`endif
    end

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] mainQ, skidQ;
    logic             main_ld, main_from_skid, skid_ld;
    logic             flush;

    assign flush = rst | clr;

    // Next-state and register load enables. In EMPTY/BUSY iRdy is high
    // whenever no flush is pending, so iVld alone marks an upstream transfer.
    // A flush overrides every load in the sequential blocks below.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (iVld) begin
                    main_ld = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (iVld && oRdy) begin
                    main_ld = 1'b1;          // pass-through
                end else if (iVld) begin
                    skid_ld = 1'b1;          // consumer stalled: skid the word
                    state_d = FULL;
                end else if (oRdy) begin
                    state_d = EMPTY;         // mainQ keeps stale value
                end
            end
            FULL: begin
                if (oRdy) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (flush)        mainQ <= INI_DATA;
        else if (main_ld) mainQ <= main_from_skid ? skidQ : iDat;
    end

    always_ff @(posedge clk) begin
        if (flush)        skidQ <= INI_DATA;
        else if (skid_ld) skidQ <= iDat;
    end

    // Only the rst/clr gating on iRdy is combinational; everything else
    // decodes from the state register.
    assign iRdy = (state_q != FULL) & ~flush;
    assign oVld = (state_q != EMPTY);
    assign oDat = mainQ;

    always_comb begin
        case (state_q)
            BUSY:    oCnt = OCNT_W'(1);
            FULL:    oCnt = OCNT_W'(2);
            default: oCnt = OCNT_W'(0);
        endcase
    end

endmodule

// File: tb/tb_zion_basic_circuit_lib_skid_reg.sv
// tb_zion_basic_circuit_lib_skid_reg
//   Directed vector table, a streaming sequence and a randomized
//   scoreboard run for the skid register (WIDTH=8, INI_DATA=8'hA5).
module tb_zion_basic_circuit_lib_skid_reg;

    localparam int         W   = 8;
    localparam logic [7:0] INI = 8'hA5;

    logic         clk = 1'b0;
    logic         rst, clr, iVld, oRdy, iRdy, oVld;
    logic [W-1:0] iDat, oDat;
    logic [1:0]   oCnt;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    zion_basic_circuit_lib_skid_reg #(.WIDTH(W), .INI_DATA(INI)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .iVld(iVld), .iRdy(iRdy), .iDat(iDat),
        .oVld(oVld), .oRdy(oRdy), .oDat(oDat), .oCnt(oCnt)
    );

    typedef struct {
        logic       rst, clr, vld, rdy;
        logic [7:0] dat;
        logic       e_irdy, e_ovld;
        logic [1:0] e_cnt;
        logic [7:0] e_dat;
    } vec_t;

    vec_t tv[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        byte unsigned q[$];
        // Each row: inputs driven for one cycle, expected outputs sampled
        // before the following rising edge (state from the previous edge).
        //        rst clr vld rdy dat      iRdy oVld cnt dat
        tv[0]  = '{1, 0, 0, 0, 8'h00,   0, 0, 0, 8'hA5};  // in reset
        tv[1]  = '{0, 0, 0, 1, 8'h00,   1, 0, 0, 8'hA5};  // first cycle after
        tv[2]  = '{0, 0, 1, 1, 8'h01,   1, 0, 0, 8'hA5};
        tv[3]  = '{0, 0, 1, 1, 8'h02,   1, 1, 1, 8'h01};
        tv[4]  = '{0, 0, 1, 1, 8'h03,   1, 1, 1, 8'h02};
        tv[5]  = '{0, 0, 0, 1, 8'h00,   1, 1, 1, 8'h03};  // drain
        tv[6]  = '{0, 0, 0, 1, 8'h00,   1, 0, 0, 8'h03};  // stale data held
        tv[7]  = '{0, 0, 1, 0, 8'h11,   1, 0, 0, 8'h03};
        tv[8]  = '{0, 0, 1, 0, 8'h22,   1, 1, 1, 8'h11};  // stall, 22 to skid
        tv[9]  = '{0, 0, 1, 0, 8'h99,   0, 1, 2, 8'h11};  // full, 99 refused
        tv[10] = '{0, 0, 1, 1, 8'h99,   0, 1, 2, 8'h11};  // oRdy rises
        tv[11] = '{0, 0, 0, 1, 8'h00,   1, 1, 1, 8'h22};  // iRdy back
        tv[12] = '{0, 0, 0, 0, 8'h00,   1, 0, 0, 8'h22};
        tv[13] = '{0, 0, 1, 0, 8'h44,   1, 0, 0, 8'h22};
        tv[14] = '{0, 0, 1, 0, 8'h55,   1, 1, 1, 8'h44};
        tv[15] = '{0, 1, 1, 1, 8'h66,   0, 1, 2, 8'h44};  // clr while full
        tv[16] = '{0, 0, 0, 1, 8'h00,   1, 0, 0, 8'hA5};
        tv[17] = '{0, 0, 1, 1, 8'h77,   1, 0, 0, 8'hA5};
        tv[18] = '{0, 0, 0, 0, 8'h00,   1, 1, 1, 8'h77};
        tv[19] = '{1, 0, 1, 1, 8'h88,   0, 1, 1, 8'h77};  // rst mid-operation
        tv[20] = '{0, 0, 0, 0, 8'h00,   1, 0, 0, 8'hA5};
        tv[21] = '{0, 0, 1, 0, 8'hAA,   1, 0, 0, 8'hA5};
        tv[22] = '{1, 1, 1, 1, 8'hBB,   0, 1, 1, 8'hAA};  // rst and clr together
        tv[23] = '{0, 0, 0, 0, 8'h00,   1, 0, 0, 8'hA5};

        rst = 1'b1; clr = 1'b0; iVld = 1'b0; oRdy = 1'b0; iDat = '0;
        @(posedge clk);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst = tv[i].rst; clr = tv[i].clr; iVld = tv[i].vld;
            oRdy = tv[i].rdy; iDat = tv[i].dat;
            #1;
            chk($sformatf("vec%0d.iRdy", i), 32'(iRdy), 32'(tv[i].e_irdy));
            chk($sformatf("vec%0d.oVld", i), 32'(oVld), 32'(tv[i].e_ovld));
            chk($sformatf("vec%0d.oCnt", i), 32'(oCnt), 32'(tv[i].e_cnt));
            chk($sformatf("vec%0d.oDat", i), 32'(oDat), 32'(tv[i].e_dat));
            @(posedge clk);
        end

        // Back-to-back stream 01..10 with oRdy held high.
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            rst = 1'b0; clr = 1'b0; iVld = 1'b1; oRdy = 1'b1; iDat = 8'(i);
            #1;
            chk($sformatf("stream%0d.iRdy", i), 32'(iRdy), 32'd1);
            if (i > 1) begin
                chk($sformatf("stream%0d.oVld", i), 32'(oVld), 32'd1);
                chk($sformatf("stream%0d.oDat", i), 32'(oDat), 32'(i - 1));
            end
            @(posedge clk);
        end
        @(negedge clk);
        iVld = 1'b0;
        #1;
        chk("stream_last.oDat", 32'(oDat), 32'h10);
        chk("stream_last.oCnt", 32'(oCnt), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("stream_end.oVld", 32'(oVld), 32'd0);

        // Random traffic against a queue model; starts from EMPTY.
        for (int c = 0; c < 10000; c++) begin
            logic up, dn;
            @(negedge clk);
            iVld = 1'($urandom_range(0, 1));
            oRdy = 1'($urandom_range(0, 3) != 0);
            iDat = 8'($urandom);
            #1;
            chk("rnd.oCnt", 32'(oCnt), 32'(q.size()));
            chk("rnd.oVld", 32'(oVld), 32'(q.size() != 0));
            chk("rnd.iRdy", 32'(iRdy), 32'(q.size() != 2));
            if (q.size() != 0) chk("rnd.oDat", 32'(oDat), 32'(q[0]));
            up = iVld && (q.size() != 2);
            dn = (q.size() != 0) && oRdy;
            @(posedge clk);
            if (dn) void'(q.pop_front());
            if (up) q.push_back(iDat);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/zion_basic_circuit_lib_skid_reg.md
# zion_basic_circuit_lib_skid_reg

Two-entry valid/ready register slice (skid buffer) that breaks both the forward data/valid path and the backward ready path between two pipeline stages. It is the handshake-aware stage placed directly upstream of the plain reset DFF response register. It decouples a producer from a consumer that may stall, and sustains one transfer per cycle at full throughput.

## Interface
- WIDTH, 8, data width in bits; must be ≥1.
- INI_DATA, '0, value loaded into both data registers on rst/clr.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous flush, active-high; lower priority than rst.
- iVld  in  1  upstream data valid.
- iRdy  out  1  upstream ready; registered, depends only on state and rst/clr.
- iDat  in  WIDTH  upstream data.
- oVld  out  1  downstream data valid.
- oRdy  in  1  downstream ready.
- oDat  out  WIDTH  downstream data; driven directly from the main register.
- oCnt  out  2  occupancy: 0, 1 or 2.

## Operation
- Storage: a main register (mainQ) drives oDat, and a skid register (skidQ) holds overflow.
- Transfers:
  - Upstream transfer = iVld & iRdy.
  - Downstream transfer = oVld & oRdy.
- States (enum): EMPTY (0 entries), BUSY (mainQ valid), FULL (mainQ and skidQ valid).
- Output decode:
  - oVld = (state != EMPTY).
  - iRdy = (state != FULL) & !rst & !clr.
  - oCnt = 0/1/2 for EMPTY/BUSY/FULL.
- Transitions, when not in rst/clr:
  - EMPTY, iVld → mainQ <= iDat; go to BUSY.
  - EMPTY, !iVld → hold.
  - BUSY, iVld & oRdy → mainQ <= iDat; stay in BUSY (pass-through, 1 transfer/cycle).
  - BUSY, iVld & !oRdy → skidQ <= iDat; go to FULL.
  - BUSY, !iVld & oRdy → go to EMPTY; mainQ keeps its stale value.
  - BUSY, !iVld & !oRdy → hold.
  - FULL, oRdy → mainQ <= skidQ; go to BUSY. No upstream accept, because iRdy = 0.
  - FULL, !oRdy → hold.
- Ordering: strict FIFO; no data is lost or duplicated.
- oDat when oVld = 0 is don't-care for consumers, but the RTL holds its last value.
- rst or clr:
  - state <= EMPTY; mainQ, skidQ <= INI_DATA.
  - Any handshake presented in that cycle is discarded. iRdy is 0 in that cycle, so upstream sees no acceptance.
- Elaboration check: WIDTH < 1 → $error. $finish is called only under CHECK_ERR_EXIT.

## Timing
- Latency: data accepted at edge N is visible on oDat, with oVld = 1, after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle while oRdy stays high.
- Combinational paths: none from oRdy to iRdy and none from iVld to oVld. All outputs are derived from registers except the rst/clr gating on iRdy.
- Stall response: after oRdy falls, at most one further word is accepted (into skidQ). iRdy falls on the following cycle.
- Recovery: from FULL, iRdy returns high one cycle after the first cycle with oRdy = 1.
- Reset values: oVld = 0, oCnt = 0, oDat = INI_DATA. iRdy = 0 while rst is high and 1 in the first cycle after.
- Reset/clr mid-operation: contents are dropped immediately. The next cycle behaves as EMPTY after reset.
- Simultaneous rst and clr: rst behaviour applies; the visible result is identical.

## Structure
- Shared package zion_basic_circuit_lib_pkg holds:
  - state typedef: enum logic [1:0] {EMPTY, BUSY, FULL};
  - occupancy width constant (2).
- Flat module; no sub-module. The two data registers and the state register are written inline, each with a synchronous reset/clear to INI_DATA/EMPTY.

## Test plan
- Reset, WIDTH=8, INI_DATA=8'hA5: assert rst for 2 cycles → oVld=0, oCnt=0, oDat=8'hA5, iRdy=0 during rst and 1 after.
- Streaming: oRdy=1 held; send 8'h01..8'h10 back-to-back → same sequence on oDat, one per cycle, 1-cycle latency, iRdy never drops.
- Stall: in BUSY holding 8'h11, drop oRdy while iVld presents 8'h22 → 8'h22 captured in skidQ, oCnt=2, iRdy=0 next cycle. Raise oRdy → outputs 8'h11 then 8'h22 in order, iRdy=1 one cycle after oRdy rises.
- Drain: single word 8'h33, then iVld=0, oRdy=1 → oVld high for exactly one cycle, then state EMPTY, oCnt=0.
- Flush: in FULL (8'h44, 8'h55) pulse clr with iVld=1 carrying 8'h66 → 8'h66 is not accepted, next cycle oVld=0, oDat=INI_DATA, and later traffic is unaffected.
- Random: random iVld/oRdy over 10k cycles, checked against a scoreboard queue → no loss, no duplication, order preserved, oCnt always matches the model.
